// File: rtl/cpu_pkg.sv
// Shared types and constants for the UART pair sequencer and its neighbours.
package cpu_pkg;

    // Default operand / result / UART byte width.
    localparam int DEF_DATA_W = 8;

    // Clock cycles per UART bit (100 MHz / 9600 baud), used by the UART cores.
    localparam int CLK_PER_BIT = 10417;

    // Sequencer states, binary encoded.
    typedef enum logic [2:0] {
        WAIT_A   = 3'd0,
        WAIT_B   = 3'd1,
        ISSUE    = 3'd2,
        WAIT_RES = 3'd3,
        TX_REQ   = 3'd4,
        TX_HOLD  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/timeout_timer.sv
// Inter-byte timer: counts enabled cycles from a clear and flags the last
// allowed cycle. It saturates there, so it never wraps.
module timeout_timer #(
    parameter int TIMEOUT_CYC = 2_000_000,
    parameter int TMR_W       = $clog2(TIMEOUT_CYC)
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] count;

    // Count cycles since the last clear, holding at the final value.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/uart_pair_sequencer.sv
// Collects two received bytes as operands, hands them to the datapath,
// captures the result and schedules it onto the UART transmitter.
module uart_pair_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = 2_000_000,
    parameter int TMR_W       = $clog2(TIMEOUT_CYC)
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              op_valid,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              op_ready,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    output logic              busy,
    output logic              timeout_err,
    output logic              overrun
);

    seq_state_t state;
    logic       tmr_clear;
    logic       tmr_enable;
    logic       tmr_expired;

    // The timer restarts when byte A is taken and runs only while waiting for B.
    assign tmr_clear  = (state == WAIT_A) && rx_valid;
    assign tmr_enable = (state == WAIT_B);

    timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TMR_W       (TMR_W)
    ) u_timer (
        .sysclk  (sysclk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    // Level outputs decoded straight from the state register.
    assign op_valid = (state == ISSUE);
    assign busy     = (state != WAIT_A);

    // Sequencer FSM with its data registers and registered pulse outputs.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state       <= WAIT_A;
            op_a        <= '0;
            op_b        <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here make every pulse last exactly
            // one cycle unless a branch below re-asserts it.
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= rx_valid && (state inside {ISSUE, WAIT_RES, TX_REQ, TX_HOLD});

            case (state)
                WAIT_A: begin
                    if (rx_valid) begin
                        op_a  <= rx_data;
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    // A byte arriving on the last allowed cycle beats the timeout.
                    if (rx_valid) begin
                        op_b  <= rx_data;
                        state <= ISSUE;
                    end else if (tmr_expired) begin
                        timeout_err <= 1'b1;
                        state       <= WAIT_A;
                    end
                end
                ISSUE: begin
                    if (op_ready) begin
                        state <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        tx_data <= res_data;
                        state   <= TX_REQ;
                    end
                end
                TX_REQ: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        state    <= TX_HOLD;
                    end
                end
                TX_HOLD: begin
                    // tx_start is high only in the first TX_HOLD cycle, which
                    // serves as the guard cycle before the transmitter raises busy.
                    if (!tx_start && !tx_busy) begin
                        state <= WAIT_A;
                    end
                end
                default: begin
                    state <= WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pair_sequencer.sv
// Self-checking bench for uart_pair_sequencer: a behavioural reference model,
// a datapath responder, a UART transmitter responder, directed scenarios and
// a randomized soak.
module tb_uart_pair_sequencer;

    localparam int TC = 100;

    logic       sysclk;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       op_valid;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_ready;
    logic       res_valid;
    logic [7:0] res_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       busy;
    logic       timeout_err;
    logic       overrun;

    logic       tx_busy_x;
    logic       tx_force;
    bit         rnd_mode;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    uart_pair_sequencer #(
        .DATA_W      (8),
        .TIMEOUT_CYC (TC)
    ) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .op_valid    (op_valid),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_ready    (op_ready),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overrun     (overrun)
    );

    assign tx_busy = tx_busy_x | tx_force;

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    always @(posedge sysclk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Phases of one pair transaction, tracked as plain integers.
    localparam int P_IDLE = 0, P_WANT_B = 1, P_OFFER = 2, P_AWAIT = 3, P_SEND = 4, P_DRAIN = 5;
    int         m_phase;
    int         m_age;      // cycles already spent waiting for B (0 on the first)
    logic [7:0] m_a, m_b, m_tx;
    bit         m_start, m_to, m_ov, m_first;

    always @(posedge sysclk or posedge reset) begin
        if (reset) begin
            m_phase = P_IDLE; m_age = 0;
            m_a = 0; m_b = 0; m_tx = 0;
            m_start = 0; m_to = 0; m_ov = 0; m_first = 0;
        end else begin
            m_ov    = rx_valid && (m_phase >= P_OFFER);
            m_start = 0;
            m_to    = 0;
            case (m_phase)
                P_IDLE:   if (rx_valid) begin m_a = rx_data; m_age = 0; m_phase = P_WANT_B; end
                P_WANT_B: begin
                    if (rx_valid) begin
                        m_b = rx_data; m_phase = P_OFFER;
                    end else if (m_age >= TC - 1) begin
                        m_to = 1; m_phase = P_IDLE;
                    end else begin
                        m_age++;
                    end
                end
                P_OFFER:  if (op_ready) m_phase = P_AWAIT;
                P_AWAIT:  if (res_valid) begin m_tx = res_data; m_phase = P_SEND; end
                P_SEND:   if (!tx_busy) begin m_start = 1; m_first = 1; m_phase = P_DRAIN; end
                P_DRAIN:  begin
                    if (m_first) m_first = 0;
                    else if (!tx_busy) m_phase = P_IDLE;
                end
                default:  m_phase = P_IDLE;
            endcase
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge sysclk) begin
        if (reset) begin
            check("op_valid", op_valid, 0);
            check("op_a", op_a, 0);
            check("op_b", op_b, 0);
            check("tx_start", tx_start, 0);
            check("tx_data", tx_data, 0);
            check("busy", busy, 0);
            check("timeout_err", timeout_err, 0);
            check("overrun", overrun, 0);
        end else begin
            check("op_valid", op_valid, 32'(m_phase == P_OFFER));
            check("op_a", op_a, m_a);
            check("op_b", op_b, m_b);
            check("tx_start", tx_start, 32'(m_start));
            check("tx_data", tx_data, m_tx);
            check("busy", busy, 32'(m_phase != P_IDLE));
            check("timeout_err", timeout_err, 32'(m_to));
            check("overrun", overrun, 32'(m_ov));
        end
    end

    // ---------------- event counters ----------------
    int start_cnt = 0, to_cnt = 0, ov_cnt = 0, to_cyc = -1;
    always @(negedge sysclk) begin
        if (!reset) begin
            if (tx_start)    start_cnt++;
            if (timeout_err) begin to_cnt++; to_cyc = cyc; end
            if (overrun)     ov_cnt++;
        end
    end

    // ---------------- datapath responder ----------------
    bit         dp_pend = 0;
    int         dp_due  = 0;
    logic [7:0] dp_val  = 0;
    initial begin
        res_valid = 1'b0;
        res_data  = 8'h00;
        forever begin
            @(negedge sysclk);
            if (reset) begin
                dp_pend = 0;
            end else if (op_valid && op_ready && !dp_pend) begin
                dp_pend = 1;
                dp_due  = cyc + (rnd_mode ? int'($urandom_range(1, 8)) : 5);
                dp_val  = rnd_mode ? 8'($urandom) : op_b;
            end
            @(posedge sysclk);
            #1;
            res_valid = 1'b0;
            if (dp_pend && cyc == dp_due && !reset) begin
                res_valid = 1'b1;
                res_data  = dp_val;
                dp_pend   = 0;
            end
        end
    end

    // ---------------- transmitter responder ----------------
    int tx_rem = 0;
    initial begin
        tx_busy_x = 1'b0;
        forever begin
            @(negedge sysclk);
            if (reset) tx_rem = 0;
            else if (tx_start) tx_rem = rnd_mode ? int'($urandom_range(1, 12)) : 10;
            @(posedge sysclk);
            #1;
            if (tx_rem > 0 && !reset) begin tx_busy_x = 1'b1; tx_rem--; end
            else tx_busy_x = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    function automatic bit cond(input int what);
        case (what)
            0:       return op_valid == 1'b1;
            1:       return tx_start == 1'b1;
            2:       return busy == 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    // Leaves the caller on the falling edge where the condition held.
    task automatic wait_until(input int what, input int budget, input string nm);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge sysclk);
            ok = cond(what);
        end
        check(nm, 32'(ok), 1);
    endtask

    int p, t0, s0, o0;

    initial begin
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        op_ready = 1'b1; tx_force = 1'b0; rnd_mode = 0;
        #1 reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Normal pair.
        s0 = start_cnt;
        send(8'h54);
        send(8'h0C);
        @(negedge sysclk);
        check("pair_op_valid", op_valid, 1);
        check("pair_op_a", op_a, 8'h54);
        check("pair_op_b", op_b, 8'h0C);
        tick();
        @(negedge sysclk);
        check("pair_op_valid_one_cycle", op_valid, 0);
        wait_until(1, 40, "pair_tx_start_seen");
        check("pair_tx_data", tx_data, 8'h0C);
        tick();
        wait_until(2, 60, "pair_idle_seen");
        tick();
        check("pair_tx_start_count", start_cnt, s0 + 1);

        // Timeout: byte A in cycle p, first WAIT_B cycle p+1, pulse TC cycles later.
        t0 = to_cnt;
        p  = cyc;
        send(8'h54);
        repeat (105) tick();
        check("timeout_count", to_cnt, t0 + 1);
        check("timeout_cycle", to_cyc, p + 1 + TC);
        send(8'h07);
        send(8'h03);
        @(negedge sysclk);
        check("recover_op_a", op_a, 8'h07);
        check("recover_op_b", op_b, 8'h03);
        tick();
        wait_until(2, 80, "recover_idle_seen");
        tick();

        // Boundary: B on the last allowed cycle (timer == TC-1) is accepted.
        t0 = to_cnt;
        p  = cyc;
        send(8'h11);
        repeat (TC - 1) tick();
        send(8'h22);
        @(negedge sysclk);
        check("boundary_op_valid", op_valid, 1);
        check("boundary_op_b", op_b, 8'h22);
        tick();
        wait_until(2, 80, "boundary_idle_seen");
        tick();
        check("boundary_no_timeout", to_cnt, t0);

        // Overrun while waiting for the result.
        o0 = ov_cnt;
        send(8'h01);
        send(8'h02);
        tick();
        tick();
        send(8'hFF);
        tick();
        check("overrun_count", ov_cnt, o0 + 1);
        check("overrun_op_a", op_a, 8'h01);
        check("overrun_op_b", op_b, 8'h02);
        wait_until(2, 80, "overrun_idle_seen");
        tick();
        send(8'h30);
        send(8'h31);
        @(negedge sysclk);
        check("fresh_op_a", op_a, 8'h30);
        check("fresh_op_b", op_b, 8'h31);
        tick();
        wait_until(2, 80, "fresh_idle_seen");
        tick();

        // Operand backpressure then transmitter backpressure.
        op_ready = 1'b0;
        tx_force = 1'b1;
        send(8'h40);
        send(8'h41);
        for (int i = 0; i < 20; i++) begin
            @(negedge sysclk);
            check("bp_op_valid", op_valid, 1);
            check("bp_op_a", op_a, 8'h40);
            check("bp_op_b", op_b, 8'h41);
            tick();
        end
        op_ready = 1'b1;
        s0 = start_cnt;
        repeat (20) tick();
        check("bp_no_tx_start", start_cnt, s0);
        tx_force = 1'b0;
        @(negedge sysclk);
        check("bp_start_not_same_cycle", tx_start, 0);
        tick();
        @(negedge sysclk);
        check("bp_start_next_cycle", tx_start, 1);
        check("bp_tx_data", tx_data, 8'h41);
        tick();
        wait_until(2, 60, "bp_idle_seen");
        tick();

        // Reset in TX_HOLD clears every output without a clock edge.
        send(8'h61);
        send(8'h62);
        wait_until(1, 40, "rst_tx_start_seen");
        tick();
        tick();
        @(negedge sysclk);
        #2 reset = 1'b1;
        #1;
        check("rst_op_valid", op_valid, 0);
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_overrun", overrun, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        send(8'h0A);
        send(8'h05);
        @(negedge sysclk);
        check("post_rst_op_valid", op_valid, 1);
        check("post_rst_op_a", op_a, 8'h0A);
        check("post_rst_op_b", op_b, 8'h05);
        tick();
        wait_until(2, 80, "post_rst_idle_seen");
        tick();

        // Randomized soak against the model.
        rnd_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                rx_valid = 1'b0;
                repeat ($urandom_range(TC - 5, TC + 5)) tick();
            end
            rx_valid = ($urandom_range(0, 9) == 0);
            rx_data  = 8'($urandom);
            op_ready = $urandom_range(0, 1) == 1;
            tick();
        end
        rx_valid = 1'b0;
        op_ready = 1'b1;
        wait_until(2, 400, "soak_idle_seen");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
